// File: rtl/spi_word_writer_pkg.sv
// Shared SPI word/header definitions and FSM state encoding for the SPI write front end.
// Word width is also used by the LED output stage.
package spi_word_writer_pkg;

  localparam int   SPI_WORD_W  = 16;
  localparam int   HDR_CMD_BIT = 15;
  localparam logic CMD_WRITE   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    DISCARD
  } spi_state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for sck/cs_n/mosi plus a third stage for edge detection; 2-3 clk latency.
// No backpressure: pure sampling of asynchronous pins.
module spi_pin_sync (
  input  logic clk,
  input  logic sck,
  input  logic cs_n,
  input  logic mosi,
  output logic sck_rise,
  output logic cs_fall,
  output logic cs_rise,
  output logic cs_level,
  output logic mosi_s
);

  // Stage [1] is the synchronised copy, stage [2] the delayed copy for edges.
  // Left unreset so a chip select held low through reset shows no false edge.
  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  always_ff @(posedge clk) begin
    sck_q  <= {sck_q[1:0], sck};
    cs_q   <= {cs_q[1:0], cs_n};
    mosi_q <= {mosi_q[0], mosi};
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_level = cs_q[1];
  assign mosi_s   = mosi_q[1];

endmodule

// File: rtl/spi_word_writer.sv
// SPI slave that turns header+data bursts into auto-incrementing word writes; strobe 1 clk after the 16th sck rise is seen.
// No backpressure: the downstream memory must accept every strobe (strobes are >= 128 clk apart).
module spi_word_writer
  import spi_word_writer_pkg::*;
#(
  parameter int WORD_COUNT        = 336,
  parameter int ADDRESS_BUS_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sck,
  input  logic                         cs_n,
  input  logic                         mosi,
  output logic [SPI_WORD_W-1:0]        spi_data,
  output logic [ADDRESS_BUS_WIDTH:0]   spi_address,
  output logic                         spi_write_strobe,
  output logic                         frame_done,
  output logic                         overflow
);

  localparam logic [ADDRESS_BUS_WIDTH:0] ADDR_ONE = {{ADDRESS_BUS_WIDTH{1'b0}}, 1'b1};

  logic sck_rise, cs_fall, cs_rise, cs_level, mosi_s;

  spi_pin_sync u_pin_sync (
    .clk      (clk),
    .sck      (sck),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .sck_rise (sck_rise),
    .cs_fall  (cs_fall),
    .cs_rise  (cs_rise),
    .cs_level (cs_level),
    .mosi_s   (mosi_s)
  );

  spi_state_e                  state, state_nxt;
  logic [3:0]                  bit_cnt;
  logic [SPI_WORD_W-2:0]       shift_q;
  logic [ADDRESS_BUS_WIDTH:0]  addr_next;
  logic                        wrote_any;
  logic [SPI_WORD_W-1:0]       word;
  logic                        word_last;
  logic                        addr_ok;
  logic                        start, shift_en, load_addr, do_write, do_drop, frame_end;

  // The 16th bit is taken live from mosi so the full word is usable in the detect cycle.
  assign word      = {shift_q, mosi_s};
  assign word_last = &bit_cnt;
  assign addr_ok   = int'(addr_next) < WORD_COUNT;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift_en  = 1'b0;
    load_addr = 1'b0;
    do_write  = 1'b0;
    do_drop   = 1'b0;
    frame_end = 1'b0;
    if (cs_rise) begin
      // A deselect wins over a coincident sck rise; any partial word is lost.
      state_nxt = IDLE;
      frame_end = wrote_any;
    end else begin
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state_nxt = HEADER;
            start     = 1'b1;
          end else if (!cs_level) begin
            state_nxt = DISCARD;
          end
        end
        HEADER: begin
          if (sck_rise) begin
            shift_en = 1'b1;
            if (word_last) begin
              if (word[HDR_CMD_BIT] == CMD_WRITE) begin
                load_addr = 1'b1;
                state_nxt = DATA;
              end else begin
                state_nxt = DISCARD;
              end
            end
          end
        end
        DATA: begin
          if (sck_rise) begin
            shift_en = 1'b1;
            if (word_last) begin
              do_write = addr_ok;
              do_drop  = !addr_ok;
            end
          end
        end
        DISCARD: state_nxt = DISCARD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_data         <= '0;
      spi_address      <= '0;
      spi_write_strobe <= 1'b0;
      frame_done       <= 1'b0;
      overflow         <= 1'b0;
      bit_cnt          <= '0;
      shift_q          <= '0;
      addr_next        <= '0;
      wrote_any        <= 1'b0;
    end else begin
      spi_write_strobe <= do_write;
      frame_done       <= frame_end;
      if (start) begin
        bit_cnt   <= '0;
        shift_q   <= '0;
        wrote_any <= 1'b0;
        overflow  <= 1'b0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 4'd1;
        shift_q <= word[SPI_WORD_W-2:0];
      end
      if (load_addr) addr_next <= word[ADDRESS_BUS_WIDTH:0];
      if (do_write) begin
        spi_data    <= word;
        spi_address <= addr_next;
        wrote_any   <= 1'b1;
        addr_next   <= addr_next + ADDR_ONE;
      end
      if (do_drop) begin
        overflow  <= 1'b1;
        addr_next <= addr_next + ADDR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_spi_word_writer.sv
// Directed bench for spi_word_writer: SPI bursts driven at clk/8, strobes logged by a monitor.
module tb_spi_word_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic [15:0] spi_data;
  logic [12:0] spi_address;
  logic        spi_write_strobe;
  logic        frame_done;
  logic        overflow;

  spi_word_writer #(.WORD_COUNT(336), .ADDRESS_BUS_WIDTH(12)) dut (
    .clk              (clk),
    .rst              (rst),
    .sck              (sck),
    .cs_n             (cs_n),
    .mosi             (mosi),
    .spi_data         (spi_data),
    .spi_address      (spi_address),
    .spi_write_strobe (spi_write_strobe),
    .frame_done       (frame_done),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_strobe = 0;
  int fd_cnt   = 0;
  int wide_strobe = 0;
  logic prev_strobe = 1'b0;
  logic [12:0] log_addr [64];
  logic [15:0] log_data [64];
  int          log_cyc  [64];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (spi_write_strobe) begin
      if (prev_strobe) wide_strobe++;
      if (n_strobe < 64) begin
        log_addr[n_strobe] = spi_address;
        log_data[n_strobe] = spi_data;
        log_cyc[n_strobe]  = cyc;
      end
      n_strobe++;
    end
    if (frame_done) fd_cnt++;
    prev_strobe = spi_write_strobe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mode 0: mosi changes while sck is low, sampled on the rising edge; 80 ns = 8 clk per bit.
  task automatic spi_word(input logic [15:0] w, input int nbits = 16);
    for (int i = 15; i > 15 - nbits; i--) begin
      mosi = w[i];
      #40 sck = 1'b1;
      #40 sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    #80;
  endtask

  task automatic cs_high();
    #80 cs_n = 1'b1;
    mosi = 1'b0;
    #200;
  endtask

  int          base;
  int          fd_base;
  logic [15:0] d;

  initial begin
    #100 rst = 1'b0;
    #20;
    chk("reset_data",     32'(spi_data), 32'h0);
    chk("reset_addr",     32'(spi_address), 32'h0);
    chk("reset_strobe",   32'(spi_write_strobe), 32'h0);
    chk("reset_frame",    32'(frame_done), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);

    // Single write
    cs_low();
    spi_word(16'h8005);
    spi_word(16'h1234);
    cs_high();
    chk("single_count", 32'(n_strobe), 32'd1);
    chk("single_addr",  32'(log_addr[0]), 32'd5);
    chk("single_data",  32'(log_data[0]), 32'h1234);
    chk("single_frame", 32'(fd_cnt), 32'd1);
    chk("single_ovf",   32'(overflow), 32'h0);
    chk("single_hold_addr", 32'(spi_address), 32'd5);
    chk("single_hold_data", 32'(spi_data), 32'h1234);

    // Burst crossing the end of memory: 334, 335 written, 336 dropped
    base = n_strobe; fd_base = fd_cnt;
    cs_low();
    spi_word(16'h814E);
    spi_word(16'hAAAA);
    spi_word(16'h5555);
    spi_word(16'hFFFF);
    #100;
    chk("end_ovf_in_burst", 32'(overflow), 32'h1);
    cs_high();
    chk("end_count", 32'(n_strobe - base), 32'd2);
    chk("end_addr0", 32'(log_addr[base]), 32'd334);
    chk("end_data0", 32'(log_data[base]), 32'hAAAA);
    chk("end_addr1", 32'(log_addr[base+1]), 32'd335);
    chk("end_data1", 32'(log_data[base+1]), 32'h5555);
    chk("end_frame", 32'(fd_cnt - fd_base), 32'd1);
    chk("end_ovf_sticky", 32'(overflow), 32'h1);
    chk("end_hold_addr", 32'(spi_address), 32'd335);

    // Aborted word, then a clean burst; the new cs_n fall clears overflow
    base = n_strobe; fd_base = fd_cnt;
    cs_low();
    chk("ovf_clear_on_fall", 32'(overflow), 32'h0);
    spi_word(16'h8000);
    spi_word(16'hFFFF, 9);
    cs_high();
    chk("abort_count", 32'(n_strobe - base), 32'd0);
    chk("abort_frame", 32'(fd_cnt - fd_base), 32'd0);
    cs_low();
    spi_word(16'h8003);
    spi_word(16'h00FF);
    cs_high();
    chk("after_abort_count", 32'(n_strobe - base), 32'd1);
    chk("after_abort_addr",  32'(log_addr[base]), 32'd3);
    chk("after_abort_data",  32'(log_data[base]), 32'h00FF);
    chk("after_abort_frame", 32'(fd_cnt - fd_base), 32'd1);

    // Non-write command
    base = n_strobe; fd_base = fd_cnt;
    cs_low();
    spi_word(16'h0007);
    spi_word(16'h1111);
    spi_word(16'h2222);
    spi_word(16'h3333);
    spi_word(16'h4444);
    cs_high();
    chk("nowrite_count", 32'(n_strobe - base), 32'd0);
    chk("nowrite_frame", 32'(fd_cnt - fd_base), 32'd0);
    chk("nowrite_ovf",   32'(overflow), 32'h0);

    // Reset while cs_n is held low after 2 of 5 words
    base = n_strobe; fd_base = fd_cnt;
    cs_low();
    spi_word(16'h8010);
    spi_word(16'hA001);
    spi_word(16'hA002);
    #200 rst = 1'b1;
    #50 rst = 1'b0;
    #30;
    chk("rstmid_addr_cleared", 32'(spi_address), 32'h0);
    spi_word(16'hA003);
    spi_word(16'hA004);
    spi_word(16'hA005);
    cs_high();
    chk("rstmid_count", 32'(n_strobe - base), 32'd2);
    chk("rstmid_addr0", 32'(log_addr[base]), 32'h10);
    chk("rstmid_data0", 32'(log_data[base]), 32'hA001);
    chk("rstmid_addr1", 32'(log_addr[base+1]), 32'h11);
    chk("rstmid_data1", 32'(log_data[base+1]), 32'hA002);
    chk("rstmid_frame", 32'(fd_cnt - fd_base), 32'd0);
    base = n_strobe; fd_base = fd_cnt;
    cs_low();
    spi_word(16'h8020);
    spi_word(16'hBEEF);
    cs_high();
    chk("rstmid_next_count", 32'(n_strobe - base), 32'd1);
    chk("rstmid_next_addr",  32'(log_addr[base]), 32'h20);
    chk("rstmid_next_data",  32'(log_data[base]), 32'hBEEF);
    chk("rstmid_next_frame", 32'(fd_cnt - fd_base), 32'd1);

    // Max-rate 32-word burst from address 0
    base = n_strobe; fd_base = fd_cnt;
    cs_low();
    spi_word(16'h8000);
    for (int i = 0; i < 32; i++) begin
      d = 16'(i * 16'h0123) ^ 16'hC35A;
      spi_word(d);
    end
    cs_high();
    chk("burst_count", 32'(n_strobe - base), 32'd32);
    chk("burst_frame", 32'(fd_cnt - fd_base), 32'd1);
    for (int i = 0; i < 32; i++) begin
      d = 16'(i * 16'h0123) ^ 16'hC35A;
      chk($sformatf("burst_addr%0d", i), 32'(log_addr[base+i]), 32'(i));
      chk($sformatf("burst_data%0d", i), 32'(log_data[base+i]), 32'(d));
      if (i > 0)
        chk($sformatf("burst_gap%0d", i), 32'(log_cyc[base+i] - log_cyc[base+i-1]), 32'd128);
    end
    chk("strobe_width", 32'(wide_strobe), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
